// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and counter sizing for the ALU execute unit
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Iteration counter must hold 0..width-1
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response handshake bundle of the ALU execute unit
interface alu_exec_unit_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic             busy;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, hi, busy
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, hi, busy
  );

endinterface

// File: rtl/alu_exec_unit_mult_iter.sv
// rtl/alu_exec_unit_mult_iter.sv - iterative shift-add unsigned multiplier, one bit per clock
module mult_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = cnt_width(WIDTH);

  logic               run_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  // The final step's sum is handed out directly so the product is ready on the done step
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: combinational ALU, MULTU sequencing and registered outputs
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               in_ready;
  logic               accept;
  logic               is_multu;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  // A new request may only land when the output slot is empty or being drained
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_multu = (bus.alu_control == OP_MULTU);

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_multu),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .done_o    (mul_done),
    .product_o (product)
  );

  // Single-cycle ALU; SLT uses a true signed compare so it stays right when a-b overflows
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_control)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_NOR: alu_res = ~(bus.a | bus.b);
      default: alu_res = '0;
    endcase
  end

  // Next-state and output-register update; outputs hold unless consumed or replaced
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multu) begin
            state_d = ST_MUL;
            busy_d  = 1'b1;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d    = product[WIDTH-1:0];
          hi_d        = product[2*WIDTH-1:WIDTH];
          zero_d      = (product[WIDTH-1:0] == '0);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] hi_exp = '0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, output logic [31:0] r, output logic z,
                                output logic v, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; v = 1'b0; lat = 0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin s = sa + sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
      OP_SUB: begin s = sa - sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
      OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      OP_NOR: r = ~(a | b);
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        hi = p[63:32];
        lat = 32;
      end
      default: r = '0;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r, output logic z,
                        output logic v, output logic [31:0] hi, output logic hold_ok);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = op; bus.a = a; bus.b = b; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0; hold_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.busy || bus.in_ready) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    r = bus.result; z = bus.zero; v = bus.overflow; hi = bus.hi;
  endtask

  task automatic op_and_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b);
    int lat, elat;
    logic [31:0] r, hi, er;
    logic z, v, ez, ev, hold_ok;
    model(op, a, b, hi_exp, er, ez, ev, elat);
    run_op(op, a, b, lat, r, z, v, hi, hold_ok);
    check({tag, " result"}, 64'(r), 64'(er));
    check({tag, " zero"}, 64'(z), 64'(ez));
    check({tag, " overflow"}, 64'(v), 64'(ev));
    check({tag, " hi"}, 64'(hi), 64'(hi_exp));
    check({tag, " latency"}, 64'(lat), 64'(elat));
    if (op == OP_MULTU) check({tag, " busy/in_ready during MUL"}, 64'(hold_ok), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] ra, rb, er, eh;
    logic ez, ev, ok;
    int el;
    logic [3:0] ops[9];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MULTU, 4'b0011, 4'b1111};

    vt[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1};
    vt[1]  = '{OP_SUB, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0};
    vt[2]  = '{OP_SLT, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1'b0};
    vt[3]  = '{OP_NOR, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[4]  = '{OP_AND, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0};
    vt[5]  = '{4'b1111, 32'h1234,     32'h5678,      32'h0,         1'b1, 1'b0};
    vt[6]  = '{OP_OR,  32'h0F0F,      32'hF000,      32'hFF0F,      1'b0, 1'b0};
    vt[7]  = '{OP_SUB, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vt[8]  = '{OP_SLT, 32'h1,         32'h8000_0000, 32'h0,         1'b1, 1'b0};
    vt[9]  = '{OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b1, 1'b0};
    vt[10] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vt[11] = '{4'b0011, 32'hFFFF,     32'hFFFF,      32'h0,         1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.alu_control = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(bus.out_valid), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset result", 64'(bus.result), 64'(0));
    check("reset zero", 64'(bus.zero), 64'(0));
    check("reset overflow", 64'(bus.overflow), 64'(0));
    rst_n = 1'b1;
    #1 check("post-reset in_ready", 64'(bus.in_ready), 64'(1));

    // directed table
    for (int i = 0; i < 12; i++) begin
      int lat;
      logic [31:0] r, hi;
      logic z, v, hold_ok;
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, r, z, v, hi, hold_ok);
      check($sformatf("vec%0d result", i), 64'(r), 64'(vt[i].r));
      check($sformatf("vec%0d zero", i), 64'(z), 64'(vt[i].z));
      check($sformatf("vec%0d overflow", i), 64'(v), 64'(vt[i].v));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(0));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(0));
    end

    // MULTU boundary: FFFFFFFF * 2
    op_and_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    check("multu_max hi is 1", 64'(bus.hi), 64'(1));

    // backpressure
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.alu_control = OP_ADD; bus.a = 32'd10; bus.b = 32'd20;
    @(negedge clk);
    check("bp first out_valid", 64'(bus.out_valid), 64'(1));
    check("bp first result", 64'(bus.result), 64'(30));
    bus.alu_control = OP_SUB; bus.a = 32'd100; bus.b = 32'd1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.result !== 32'd30 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp hold stable", 64'(ok), 64'(1));
    bus.out_ready = 1'b1;
    #1 check("bp in_ready on drain", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp second out_valid", 64'(bus.out_valid), 64'(1));
    check("bp second result", 64'(bus.result), 64'(99));
    @(negedge clk);
    check("bp drained", 64'(bus.out_valid), 64'(0));

    // streaming 8 back-to-back ADDs
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("stream%0d out_valid", i - 1), 64'(bus.out_valid), 64'(1));
        check($sformatf("stream%0d result", i - 1), 64'(bus.result), 64'(exp_q.pop_front()));
        check($sformatf("stream%0d hi", i - 1), 64'(bus.hi), 64'(hi_exp));
      end
      if (i < 8) begin
        ra = $urandom; rb = $urandom;
        model(OP_ADD, ra, rb, hi_exp, er, ez, ev, el);
        exp_q.push_back(er);
        bus.in_valid = 1'b1; bus.alu_control = OP_ADD; bus.a = ra; bus.b = rb;
        #1 check($sformatf("stream%0d in_ready", i), 64'(bus.in_ready), 64'(1));
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // randomized against the reference model
    for (int i = 0; i < 120; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(8)];
      if ($urandom_range(15) == 0) op = 4'($urandom);
      case ($urandom_range(3))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(3))
        0: rb = 32'hFFFF_FFFF;
        1: rb = ra;
        default: rb = $urandom;
      endcase
      op_and_check($sformatf("rand%0d op%h", i, op), op, ra, rb);
    end

    // reset in the middle of a MULTU
    op_and_check("pre-reset multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-multu busy", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(bus.out_valid), 64'(0));
    check("async reset busy", 64'(bus.busy), 64'(0));
    check("async reset hi", 64'(bus.hi), 64'(0));
    check("async reset result", 64'(bus.result), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hi_exp = '0;
    #1 check("after reset in_ready", 64'(bus.in_ready), 64'(1));
    eh = '0;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("no stale result after reset", 64'(ok), 64'(1));
    check("hi after reset", 64'(bus.hi), 64'(eh));
    op_and_check("post-reset multu", OP_MULTU, 32'd3, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
